player_health: RTL and testbench
================================

PLAYER_HEALTH -- requirements
Module: player_health

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: number of independent player channels.
REQ-002 Parameter START_LIVES, default 4: lives loaded at reset; must be 1..MAX_LIVES.
REQ-003 Parameter MAX_LIVES, default 7: saturation ceiling for lives.
REQ-004 Parameter DAMAGE_FRAMES, default 30: invulnerability length in frames; must be at least 1.
REQ-005 Parameter BLINK_LOG2, default 3: faded toggles once every 2^BLINK_LOG2 frames while damaged.
REQ-006 Derived constant LIVES_W = $clog2(MAX_LIVES+1); derived constant TMR_W = $clog2(DAMAGE_FRAMES+1).
REQ-007 Ports: clk  in  1  sole clock, rising edge.
REQ-008 Ports: reset  in  1  synchronous, active-high reset.
REQ-009 Ports: enable  in  1  global advance; when low, all state holds.
REQ-010 Ports: startOfFrame  in  1  one-cycle frame tick.
REQ-011 Ports: hit  in  NUM_PLAYERS  per-player missile collision.
REQ-012 Ports: extra_life  in  NUM_PLAYERS  per-player life pickup (used only with the macro).
REQ-013 Ports: lives  out  NUM_PLAYERS*LIVES_W  packed per-player lives count; player i occupies bits [i*LIVES_W +: LIVES_W].
REQ-014 Ports: player_faded  out  NUM_PLAYERS  per-player faded (blink or dead) flag.
REQ-015 Ports: player_dead  out  NUM_PLAYERS  per-player dead flag.
REQ-016 Ports: all_dead  out  1  game-over flag, equal to the AND of player_dead.

Function
REQ-017 Each channel runs an FSM with three states, ALIVE, DAMAGED and DEAD, and updates only in cycles where enable=1.
REQ-018 In ALIVE with hit=1 and lives>1, the channel SHALL, on the next edge: decrement lives, enter DAMAGED, load the timer with DAMAGE_FRAMES and set faded=1.
REQ-019 In ALIVE with hit=1 and lives==1, the channel SHALL, on the next edge: set lives=0, enter DEAD, and set dead=1 and faded=1, with no intermediate cycle.
REQ-020 In DAMAGED, hit is ignored and lives are unchanged by it.
REQ-021 In DAMAGED, each startOfFrame SHALL decrement the timer by 1.
REQ-022 In DAMAGED, on a startOfFrame where timer[BLINK_LOG2-1:0]==0 before the decrement, faded SHALL toggle.
REQ-023 In DAMAGED, when a startOfFrame decrements the timer from 1 to 0, the channel SHALL enter ALIVE with faded=0 on that same edge.
REQ-024 In ALIVE, faded SHALL be 0.
REQ-025 DEAD is absorbing until reset: dead=1, faded=1, lives=0, and hit and extra_life are ignored.
REQ-026 All lives arithmetic is LIVES_W wide, and lives SHALL never wrap below 0 or above MAX_LIVES.
REQ-027 When hit and startOfFrame coincide in ALIVE, the hit takes effect and the timer loads DAMAGE_FRAMES without decrementing.
REQ-028 Channels are fully independent; simultaneous hits on several players are each processed in the same cycle.
REQ-029 all_dead is combinational from the registered player_dead bits.

Reset
REQ-030 While reset=1 on a clk edge, every channel SHALL go to ALIVE with lives=START_LIVES, timer=0, faded=0 and dead=0.
REQ-031 Reset overrides enable, so reset applies even when enable=0.
REQ-032 Reset asserted mid-DAMAGED or in DEAD SHALL fully restore the reset values on the next edge.

Configuration
REQ-033 With PLAYER_HEALTH_EXTRA_LIFE_EN defined, extra_life=1 in ALIVE or DAMAGED SHALL increment lives, saturating at MAX_LIVES.
REQ-034 With PLAYER_HEALTH_EXTRA_LIFE_EN defined, extra_life and hit together in ALIVE SHALL leave lives unchanged and enter DAMAGED; the player never dies from this case, even when lives==1.
REQ-035 With PLAYER_HEALTH_EXTRA_LIFE_EN defined, extra_life in DAMAGED SHALL increment lives without disturbing the timer.
REQ-036 Without PLAYER_HEALTH_EXTRA_LIFE_EN, the extra_life port SHALL still exist, be ignored, and generate no logic.

Structure
REQ-037 The state enum (ALIVE, DAMAGED, DEAD) SHALL live in shared package player_pkg.
REQ-038 The default parameter constants SHALL live in shared package player_pkg.
REQ-039 One sub-module, player_health_channel, implements one channel's FSM, timer and lives.
REQ-040 player_health SHALL generate NUM_PLAYERS instances of player_health_channel and compute all_dead.

Verification
REQ-041 Scenario: defaults, single hit on player 0 -> lives[0] goes 4->3 and faded=1 next cycle; exactly 30 frames later faded=0 and state is ALIVE.
REQ-042 Scenario: hit held high throughout DAMAGED -> lives stay 3; faded toggles on the frames where the pre-decrement timer is 24, 16 and 8.
REQ-043 Scenario: four spaced hits on player 1 -> after the 4th hit, dead[1]=1 and faded[1]=1 the next cycle, lives[1]=0, and all_dead=0 while player 0 is alive.
REQ-044 Scenario: both players killed -> all_dead=1; then reset=1 for one edge -> lives=4/4, all flags 0.
REQ-045 Scenario (macro on): lives=7 plus extra_life -> lives stay 7; lives=1 with hit and extra_life in the same cycle -> lives=1, DAMAGED, dead=0.
REQ-046 Scenario: enable=0 during DAMAGED over 10 frames -> timer, faded and lives frozen; resume with enable=1 -> countdown continues from the held value.

Source files
------------

// File: rtl/player_pkg.sv
// Shared state encoding and default constants for the player health block.
package player_pkg;

  localparam int PH_NUM_PLAYERS   = 2;
  localparam int PH_START_LIVES   = 4;
  localparam int PH_MAX_LIVES     = 7;
  localparam int PH_DAMAGE_FRAMES = 30;
  localparam int PH_BLINK_LOG2    = 3;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    DAMAGED = 2'd1,
    DEAD    = 2'd2
  } ph_state_t;

endpackage

// File: rtl/player_health_channel.sv
// One player's health FSM: lives, invulnerability timer and blink/dead flags.
// Extra-life pickups are honoured only when PLAYER_HEALTH_EXTRA_LIFE_EN is defined.
module player_health_channel
  import player_pkg::*;
#(
  parameter int  START_LIVES   = PH_START_LIVES,
  parameter int  MAX_LIVES     = PH_MAX_LIVES,
  parameter int  DAMAGE_FRAMES = PH_DAMAGE_FRAMES,
  parameter int  BLINK_LOG2    = PH_BLINK_LOG2,
  localparam int LIVES_W       = $clog2(MAX_LIVES + 1)
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               startOfFrame,
  input  logic               hit,
  input  logic               extra_life,
  output logic [LIVES_W-1:0] lives,
  output logic               faded,
  output logic               dead
);

  localparam int TMR_W   = $clog2(DAMAGE_FRAMES + 1);
  localparam int BLINK_W = (BLINK_LOG2 < TMR_W) ? BLINK_LOG2 : TMR_W;
  localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_MAX   = LIVES_W'(MAX_LIVES);
  localparam logic [TMR_W-1:0]   TMR_LOAD    = TMR_W'(DAMAGE_FRAMES);

  ph_state_t          state_r;
  logic [TMR_W-1:0]   timer_r;
  logic [LIVES_W-1:0] lives_r;
  logic               faded_r;
  logic               dead_r;
  logic [LIVES_W-1:0] lives_inc_s;
  logic               blink_s;
  logic               xl_s;

`ifdef PLAYER_HEALTH_EXTRA_LIFE_EN
  assign xl_s = extra_life;
`else
  logic unused_extra_life_s;
  assign unused_extra_life_s = extra_life;
  assign xl_s = 1'b0;
`endif

  assign blink_s = (timer_r[BLINK_W-1:0] == {BLINK_W{1'b0}});

  // Saturating lives increment for pickups.
  always_comb begin
    lives_inc_s = lives_r;
    if (lives_r < LIVES_MAX) begin
      lives_inc_s = lives_r + LIVES_W'(1);
    end else begin
      lives_inc_s = LIVES_MAX;
    end
  end

  // Channel state, timer, lives and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ALIVE;
      timer_r <= {TMR_W{1'b0}};
      lives_r <= LIVES_START;
      faded_r <= 1'b0;
      dead_r  <= 1'b0;
    end else if (enable) begin
      case (state_r)
        ALIVE: begin
          faded_r <= 1'b0;
          if (hit && xl_s) begin
            // Pickup cancels the loss, but the hit still grants invulnerability.
            state_r <= DAMAGED;
            timer_r <= TMR_LOAD;
            faded_r <= 1'b1;
          end else if (hit && (lives_r > LIVES_W'(1))) begin
            lives_r <= lives_r - LIVES_W'(1);
            state_r <= DAMAGED;
            timer_r <= TMR_LOAD;
            faded_r <= 1'b1;
          end else if (hit) begin
            lives_r <= {LIVES_W{1'b0}};
            state_r <= DEAD;
            faded_r <= 1'b1;
            dead_r  <= 1'b1;
          end else if (xl_s) begin
            lives_r <= lives_inc_s;
          end
        end
        DAMAGED: begin
          if (xl_s) begin
            lives_r <= lives_inc_s;
          end
          if (startOfFrame) begin
            if (timer_r <= TMR_W'(1)) begin
              state_r <= ALIVE;
              timer_r <= {TMR_W{1'b0}};
              faded_r <= 1'b0;
            end else begin
              timer_r <= timer_r - TMR_W'(1);
              if (blink_s) begin
                faded_r <= ~faded_r;
              end
            end
          end
        end
        DEAD: begin
          lives_r <= {LIVES_W{1'b0}};
          faded_r <= 1'b1;
          dead_r  <= 1'b1;
        end
        default: begin
          state_r <= ALIVE;
          timer_r <= {TMR_W{1'b0}};
          lives_r <= LIVES_START;
          faded_r <= 1'b0;
          dead_r  <= 1'b0;
        end
      endcase
    end
  end

  assign lives = lives_r;
  assign faded = faded_r;
  assign dead  = dead_r;

endmodule

// File: rtl/player_health.sv
// Multi-player health tracker: one independent channel per player plus game-over.
// Optional feature macro: PLAYER_HEALTH_EXTRA_LIFE_EN (extra-life pickups).
module player_health
  import player_pkg::*;
#(
  parameter int  NUM_PLAYERS   = PH_NUM_PLAYERS,
  parameter int  START_LIVES   = PH_START_LIVES,
  parameter int  MAX_LIVES     = PH_MAX_LIVES,
  parameter int  DAMAGE_FRAMES = PH_DAMAGE_FRAMES,
  parameter int  BLINK_LOG2    = PH_BLINK_LOG2,
  localparam int LIVES_W       = $clog2(MAX_LIVES + 1)
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           startOfFrame,
  input  logic [NUM_PLAYERS-1:0]         hit,
  input  logic [NUM_PLAYERS-1:0]         extra_life,
  output logic [NUM_PLAYERS*LIVES_W-1:0] lives,
  output logic [NUM_PLAYERS-1:0]         player_faded,
  output logic [NUM_PLAYERS-1:0]         player_dead,
  output logic                           all_dead
);

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
    player_health_channel #(
      .START_LIVES  (START_LIVES),
      .MAX_LIVES    (MAX_LIVES),
      .DAMAGE_FRAMES(DAMAGE_FRAMES),
      .BLINK_LOG2   (BLINK_LOG2)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .startOfFrame(startOfFrame),
      .hit         (hit[i]),
      .extra_life  (extra_life[i]),
      .lives       (lives[i*LIVES_W +: LIVES_W]),
      .faded       (player_faded[i]),
      .dead        (player_dead[i])
    );
  end

  assign all_dead = &player_dead;

endmodule

// File: tb/tb_player_health.sv
// Self-checking bench for player_health: frame-level reference model plus directed scenarios.
module tb_player_health;
  localparam int NP = 2, START = 4, MAXL = 7, DF = 30, BL = 3, LW = 3;

  logic clk = 1'b0;
  logic reset, enable, startOfFrame;
  logic [NP-1:0] hit, extra_life;
  logic [NP*LW-1:0] lives;
  logic [NP-1:0] player_faded, player_dead;
  logic all_dead;

  int tests = 0, fails = 0;
  int m_lives[NP];
  int m_st[NP];   // 0 alive, 1 invulnerable, 2 dead
  int m_tmr[NP];  // frames of invulnerability remaining

  player_health dut (
    .clk(clk), .reset(reset), .enable(enable), .startOfFrame(startOfFrame),
    .hit(hit), .extra_life(extra_life), .lives(lives),
    .player_faded(player_faded), .player_dead(player_dead), .all_dead(all_dead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level rules applied to one sampled clock edge.
  task automatic model_step(input logic r, input logic en, input logic sof,
                            input logic [NP-1:0] h, input logic [NP-1:0] x);
    for (int p = 0; p < NP; p++) begin
      bit xl;
`ifdef PLAYER_HEALTH_EXTRA_LIFE_EN
      xl = x[p];
`else
      xl = x[p] & 1'b0;
`endif
      if (r) begin
        m_lives[p] = START; m_st[p] = 0; m_tmr[p] = 0;
      end else if (en) begin
        if (m_st[p] == 0) begin
          if (h[p] && xl) begin
            m_st[p] = 1; m_tmr[p] = DF;
          end else if (h[p] && m_lives[p] > 1) begin
            m_lives[p] = m_lives[p] - 1; m_st[p] = 1; m_tmr[p] = DF;
          end else if (h[p]) begin
            m_lives[p] = 0; m_st[p] = 2;
          end else if (xl) begin
            m_lives[p] = (m_lives[p] < MAXL) ? m_lives[p] + 1 : MAXL;
          end
        end else if (m_st[p] == 1) begin
          if (xl) m_lives[p] = (m_lives[p] < MAXL) ? m_lives[p] + 1 : MAXL;
          if (sof) begin
            m_tmr[p] = m_tmr[p] - 1;
            if (m_tmr[p] == 0) m_st[p] = 0;
          end
        end
      end
    end
  endtask

  // Blink phase counted from how many multiples of 2^BL the timer has passed since loading.
  function automatic int exp_faded(input int p);
    if (m_st[p] == 0) return 0;
    if (m_st[p] == 2) return 1;
    return 1 ^ (((DF >> BL) - (m_tmr[p] >> BL)) & 1);
  endfunction

  // Compare process: every edge, step the model and check all outputs.
  initial begin
    logic r, e, s;
    logic [NP-1:0] h, x;
    int ad;
    forever begin
      @(posedge clk);
      r = reset; e = enable; s = startOfFrame; h = hit; x = extra_life;
      #1;
      model_step(r, e, s, h, x);
      ad = 1;
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("model lives p%0d", p), int'(lives[p*LW +: LW]), m_lives[p]);
        chk($sformatf("model faded p%0d", p), int'(player_faded[p]), exp_faded(p));
        chk($sformatf("model dead p%0d", p), int'(player_dead[p]), (m_st[p] == 2) ? 1 : 0);
        if (m_st[p] != 2) ad = 0;
      end
      chk("model all_dead", int'(all_dead), ad);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1; @(negedge clk);
      startOfFrame = 1'b0; @(negedge clk);
    end
  endtask

  task automatic pulse_hit(input logic [NP-1:0] m);
    hit = m; @(negedge clk); hit = '0;
  endtask

  function automatic int lv(input int p);
    return int'(lives[p*LW +: LW]);
  endfunction

  initial begin
    int cnt, first, prev;
    reset = 1'b1; enable = 1'b1; startOfFrame = 1'b0; hit = '0; extra_life = '0;
    cyc(2);
    reset = 1'b0;
    chk("reset lives", int'(lives), 36);
    chk("reset faded", int'(player_faded), 0);
    chk("reset dead", int'(player_dead), 0);
    chk("reset all_dead", int'(all_dead), 0);

    // Single hit on player 0, invulnerable for exactly 30 frames.
    pulse_hit(2'b01);
    chk("hit lives0", lv(0), 3);
    chk("hit faded0", int'(player_faded[0]), 1);
    chk("hit lives1 untouched", lv(1), 4);
    frames(29);
    pulse_hit(2'b01);
    chk("hit ignored at frame 29", lv(0), 3);
    frames(1);
    chk("faded0 clear after 30 frames", int'(player_faded[0]), 0);

    // Hit held through the whole invulnerable window.
    hit = 2'b01; @(negedge clk);
    chk("second hit lives0", lv(0), 2);
    cnt = 0; first = -1; prev = int'(player_faded[0]);
    for (int k = 1; k <= 29; k++) begin
      frames(1);
      if (int'(player_faded[0]) != prev) begin
        cnt++;
        if (first < 0) first = k;
      end
      prev = int'(player_faded[0]);
    end
    hit = '0;
    chk("held hit lives0", lv(0), 2);
    chk("blink toggle count", cnt, 3);
    chk("first toggle frame", first, 7);
    frames(1);
    chk("held hit back alive", int'(player_faded[0]), 0);

    // Four spaced hits on player 1; first coincides with a frame tick.
    hit = 2'b10; startOfFrame = 1'b1; @(negedge clk);
    hit = '0; startOfFrame = 1'b0;
    frames(29);
    pulse_hit(2'b10);
    chk("coincident hit timer full", lv(1), 3);
    frames(1);
    for (int n = 0; n < 2; n++) begin
      pulse_hit(2'b10);
      frames(30);
    end
    pulse_hit(2'b10);
    chk("p1 dead", int'(player_dead[1]), 1);
    chk("p1 faded", int'(player_faded[1]), 1);
    chk("p1 lives", lv(1), 0);
    chk("all_dead with p0 alive", int'(all_dead), 0);
    pulse_hit(2'b10);
    frames(2);

    // Kill player 0 as well, then reset.
    pulse_hit(2'b01);
    frames(30);
    pulse_hit(2'b01);
    chk("all_dead both", int'(all_dead), 1);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("post-reset lives", int'(lives), 36);
    chk("post-reset flags", int'({player_faded, player_dead, all_dead}), 0);

    // Simultaneous hits, then freeze with enable low.
    pulse_hit(2'b11);
    chk("simultaneous hit lives", int'(lives), 27);
    frames(5);
    enable = 1'b0;
    frames(10);
    pulse_hit(2'b11);
    chk("frozen faded0", int'(player_faded[0]), 1);
    chk("frozen lives", int'(lives), 27);
    enable = 1'b1;
    frames(2);
    chk("resumed toggle faded0", int'(player_faded[0]), 0);
    frames(22);
    pulse_hit(2'b01);
    chk("resumed still invulnerable", lv(0), 3);
    frames(1);
    pulse_hit(2'b01);
    chk("resumed alive again", lv(0), 2);

    // Reset overrides enable while damaged.
    enable = 1'b0; reset = 1'b1; @(negedge clk);
    reset = 1'b0; enable = 1'b1;
    chk("reset with enable low lives", int'(lives), 36);
    chk("reset with enable low faded", int'(player_faded), 0);

`ifdef PLAYER_HEALTH_EXTRA_LIFE_EN
    extra_life = 2'b11; cyc(5); extra_life = '0;
    chk("extra life saturates", int'(lives), 63);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    pulse_hit(2'b01); frames(30);
    pulse_hit(2'b01); frames(30);
    pulse_hit(2'b01); frames(30);
    chk("p0 down to one", lv(0), 1);
    hit = 2'b01; extra_life = 2'b01; @(negedge clk);
    hit = '0; extra_life = '0;
    chk("hit+extra lives", lv(0), 1);
    chk("hit+extra faded", int'(player_faded[0]), 1);
    chk("hit+extra not dead", int'(player_dead[0]), 0);
    frames(3);
    extra_life = 2'b01; @(negedge clk); extra_life = '0;
    chk("extra in damaged", lv(0), 2);
    frames(27);
`else
    extra_life = 2'b11; cyc(3); extra_life = '0;
    chk("extra life ignored", int'(lives), 36);
`endif
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
